// File: rtl/stage_share_arbiter.sv
// Round-robin front end that shares one fixed-latency 2-bit stage among NREQ requesters.
// A tag pipeline steers each stage result back into that requester's response register.
module stage_share_arbiter #(
   parameter int unsigned NREQ = 6,
   parameter int unsigned LAT  = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREQ-1:0]     REQ_VALID,
   input  logic [2*NREQ-1:0]   REQ_DATA,
   output logic [NREQ-1:0]     REQ_READY,
   output logic [1:0]          STG_I,
   output logic                STG_VALID,
   input  logic [1:0]          STG_O,
   output logic [NREQ-1:0]     RSP_VALID,
   output logic [2*NREQ-1:0]   RSP_DATA,
   input  logic [NREQ-1:0]     RSP_READY,
   output logic                BUSY
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] outstanding;
   logic [NREQ-1:0] outstanding_nxt;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] rsp_xfer;
   logic [IW-1:0]   last;
   logic [IW-1:0]   gnt_idx;
   logic [IW-1:0]   cand;
   logic            gnt_any;
   logic [1:0]      gnt_data;
   logic [LAT:0]    pipe_vld;
   logic [IW-1:0]   pipe_tag [LAT+1];

   assign eligible        = REQ_VALID & ~outstanding;
   assign rsp_xfer        = RSP_VALID & RSP_READY;
   assign outstanding_nxt = (outstanding & ~rsp_xfer) | REQ_READY;

   // Search upward from last+1 with wrap; the first eligible index wins.
   always_comb begin
      REQ_READY = '0;
      gnt_idx   = last;
      gnt_any   = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if ((32'(last) + i) >= NREQ) begin
            cand = IW'(32'(last) + i - NREQ);
         end else begin
            cand = IW'(32'(last) + i);
         end
         if (!gnt_any && !RST && eligible[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) begin
         REQ_READY[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (REQ_READY[k]) begin
            gnt_data = REQ_DATA[2*k +: 2];
         end
      end
   end

   // Issue register, tag pipeline aligned with STG_O, and response capture.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         outstanding <= '0;
         last        <= IW'(NREQ - 1);
         STG_VALID   <= 1'b0;
         STG_I       <= '0;
         RSP_VALID   <= '0;
         RSP_DATA    <= '0;
         BUSY        <= 1'b0;
         pipe_vld    <= '0;
         for (int unsigned i = 0; i <= LAT; i++) begin
            pipe_tag[i] <= '0;
         end
      end else begin
         outstanding <= outstanding_nxt;
         BUSY        <= |outstanding_nxt;
         STG_VALID   <= gnt_any;
         STG_I       <= gnt_data;
         if (gnt_any) begin
            last <= gnt_idx;
         end
         pipe_vld    <= {pipe_vld[LAT-1:0], gnt_any};
         pipe_tag[0] <= gnt_idx;
         for (int unsigned i = 1; i <= LAT; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
         end
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (rsp_xfer[k]) begin
               RSP_VALID[k] <= 1'b0;
            end
            if (pipe_vld[LAT] && (pipe_tag[LAT] == IW'(k))) begin
               RSP_VALID[k]       <= 1'b1;
               RSP_DATA[2*k +: 2] <= STG_O;
            end
         end
      end
   end

endmodule

// File: tb/tb_stage_share_arbiter.sv
// Bench for stage_share_arbiter: stage modelled as an LAT-cycle inverting delay line,
// with a grant/outstanding model and issue/response scoreboards checked every cycle.
module tb_stage_share_arbiter;

   localparam int NREQ = 6;
   localparam int LAT  = 2;

   typedef struct {
      int         due;
      int         tag;
      logic [1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [2*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_ready;
   logic [1:0]        stg_i;
   logic              stg_valid;
   logic [1:0]        stg_o;
   logic [NREQ-1:0]   rsp_valid;
   logic [2*NREQ-1:0] rsp_data;
   logic [NREQ-1:0]   rsp_ready = '1;
   logic              busy;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   exp_t            stg_q[$];
   exp_t            rsp_q[$];
   logic [NREQ-1:0] m_out   = '0;
   int              m_last  = NREQ - 1;
   logic [NREQ-1:0] seen    = '0;
   logic [NREQ-1:0] xfer_s  = '0;
   logic [1:0]      held [NREQ];
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] exp_gnt;
   int              gidx;
   int              jj;
   bit              auto_data = 1'b0;
   logic [1:0]      dl [LAT];

   stage_share_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data), .REQ_READY(req_ready),
      .STG_I(stg_i), .STG_VALID(stg_valid), .STG_O(stg_o), .RSP_VALID(rsp_valid),
      .RSP_DATA(rsp_data), .RSP_READY(rsp_ready), .BUSY(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Shared stage: STG_O = ~STG_I after LAT cycles, free-running and never reset.
   always @(posedge clk) begin
      dl[0] <= ~stg_i;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
   end
   assign stg_o = dl[LAT-1];

   // Per-cycle model check, run at the falling edge.
   task automatic monitor();
      exp_t            e;
      logic [NREQ-1:0] rsp_x;
      if (rst) begin
         stg_q.delete();
         rsp_q.delete();
         m_out  = '0;
         m_last = NREQ - 1;
         seen   = '0;
         xfer_s = '0;
      end else begin
         elig    = req_valid & ~m_out;
         exp_gnt = '0;
         gidx    = -1;
         for (int i = 1; i <= NREQ; i++) begin
            jj = (m_last + i) % NREQ;
            if (gidx < 0 && elig[jj]) gidx = jj;
         end
         if (gidx >= 0) exp_gnt[gidx] = 1'b1;
         vectors++;
         if (req_ready !== exp_gnt) begin
            errors++;
            $display("FAIL grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_gnt);
         end
         vectors++;
         if (stg_q.size() > 0 && stg_q[0].due == cyc) begin
            e = stg_q.pop_front();
            if (stg_valid !== 1'b1 || stg_i !== e.data) begin
               errors++;
               $display("FAIL issue cyc=%0d got v=%b i=%b want v=1 i=%b", cyc, stg_valid, stg_i, e.data);
            end
         end else if (stg_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_idle cyc=%0d got v=%b want v=0", cyc, stg_valid);
         end
         while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
            e = rsp_q.pop_front();
            vectors++;
            errors++;
            $display("FAIL rsp_missing cyc=%0d tag=%0d got none want due=%0d", cyc, e.tag, e.due);
         end
         for (int k = 0; k < NREQ; k++) begin
            if (rsp_valid[k] && !seen[k]) begin
               seen[k] = 1'b1;
               held[k] = rsp_data[2*k +: 2];
               vectors++;
               if (rsp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rsp_unexpected cyc=%0d got tag=%0d want none", cyc, k);
               end else begin
                  e = rsp_q.pop_front();
                  if (e.tag != k || e.due != cyc || held[k] !== e.data) begin
                     errors++;
                     $display("FAIL rsp cyc=%0d got tag=%0d d=%b want tag=%0d d=%b due=%0d",
                              cyc, k, held[k], e.tag, e.data, e.due);
                  end
               end
            end else if (rsp_valid[k]) begin
               vectors++;
               if (rsp_data[2*k +: 2] !== held[k]) begin
                  errors++;
                  $display("FAIL rsp_hold cyc=%0d k=%0d got=%b want=%b", cyc, k, rsp_data[2*k +: 2], held[k]);
               end
            end
         end
         vectors++;
         if (busy !== (|m_out)) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, |m_out);
         end
         rsp_x  = rsp_valid & rsp_ready;
         xfer_s = exp_gnt;
         for (int k = 0; k < NREQ; k++) if (rsp_x[k]) seen[k] = 1'b0;
         if (gidx >= 0) begin
            e.tag  = gidx;
            e.due  = cyc + 1;
            e.data = req_data[2*gidx +: 2];
            stg_q.push_back(e);
            e.due  = cyc + 2 + LAT;
            e.data = ~req_data[2*gidx +: 2];
            rsp_q.push_back(e);
            m_last = gidx;
         end
         m_out = (m_out & ~rsp_x) | exp_gnt;
      end
   endtask

   task automatic half();
      @(negedge clk);
      monitor();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++)
         if (auto_data && xfer_s[k]) req_data[2*k +: 2] = 2'($urandom);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      req_valid = '0;
      auto_data = 1'b0;
      rsp_ready = '1;
      for (int n = 0; n < 12; n++) begin
         half();
         if (busy === 1'b0 && rsp_valid === '0) ok = 1'b1;
         tick();
      end
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL drain got busy=%b want 0 within 12 cycles", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0;
      half();
      vectors++;
      if ({req_ready, stg_valid, stg_i, rsp_valid, rsp_data, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b sv=%b si=%b rv=%b rd=%b busy=%b want all 0",
                  req_ready, stg_valid, stg_i, rsp_valid, rsp_data, busy);
      end
      req_valid = '1;
      #1;
      vectors++;
      if (req_ready !== '0) begin
         errors++;
         $display("FAIL reset_ready got=%b want=000000", req_ready);
      end
      tick();
      half();
      tick();
      rst = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_full_load();
      logic [NREQ-1:0] want;
      auto_data = 1'b1;
      req_data  = 12'($urandom);
      req_valid = '1;
      for (int c = 0; c < 14; c++) begin
         half();
         want = NREQ'(1 << (c % NREQ));
         vectors++;
         if (req_ready !== want) begin
            errors++;
            $display("FAIL full_load_grant c=%0d got=%b want=%b", c, req_ready, want);
         end
         if (c >= 1) begin
            vectors++;
            if (stg_valid !== 1'b1) begin
               errors++;
               $display("FAIL full_load_stream c=%0d got=%b want=1", c, stg_valid);
            end
         end
         tick();
      end
      drain();
   endtask

   task automatic test_single();
      req_data  = 12'h080;
      req_valid = 6'b001000;
      half();
      vectors++;
      if (req_ready !== 6'b001000) begin
         errors++;
         $display("FAIL single_grant got=%b want=001000", req_ready);
      end
      tick();
      req_valid = '0;
      half();
      vectors++;
      if (stg_valid !== 1'b1 || stg_i !== 2'b10 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_issue got v=%b i=%b busy=%b want v=1 i=10 busy=1", stg_valid, stg_i, busy);
      end
      tick();
      for (int c = 2; c < 4; c++) begin
         half();
         vectors++;
         if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_early c=%0d got=%b want=000000", c, rsp_valid);
         end
         tick();
      end
      half();
      vectors++;
      if (rsp_valid !== 6'b001000 || rsp_data[7:6] !== 2'b01) begin
         errors++;
         $display("FAIL single_rsp got v=%b d=%b want v=001000 d=01", rsp_valid, rsp_data[7:6]);
      end
      tick();
      half();
      vectors++;
      if (busy !== 1'b0 || rsp_valid !== '0) begin
         errors++;
         $display("FAIL single_idle got busy=%b v=%b want busy=0 v=000000", busy, rsp_valid);
      end
      tick();
   endtask

   task automatic test_backpressure();
      bit         found;
      logic [1:0] hold2;
      hold2     = '0;
      auto_data = 1'b1;
      req_data  = 12'($urandom);
      rsp_ready = 6'b111011;
      req_valid = '1;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         half();
         if (rsp_valid[2] === 1'b1) begin
            found = 1'b1;
            hold2 = rsp_data[5:4];
         end
         tick();
      end
      vectors++;
      if (!found) begin
         errors++;
         $display("FAIL bp_first_rsp got none want RSP_VALID[2] within 20 cycles");
      end
      for (int c = 0; c < 10; c++) begin
         half();
         vectors++;
         if (rsp_valid[2] !== 1'b1 || rsp_data[5:4] !== hold2 || req_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold c=%0d got v=%b d=%b rdy=%b want v=1 d=%b rdy=0",
                     c, rsp_valid[2], rsp_data[5:4], req_ready[2], hold2);
         end
         tick();
      end
      found = 1'b0;
      for (int n = 0; n < 12 && !found; n++) begin
         half();
         if (req_ready === 6'b000001) found = 1'b1;
         tick();
      end
      vectors++;
      if (!found) begin
         errors++;
         $display("FAIL bp_sync got none want grant to 0 within 12 cycles");
      end
      rsp_ready = '1;
      half();
      vectors++;
      if (rsp_valid[2] !== 1'b1 || req_ready !== 6'b000010) begin
         errors++;
         $display("FAIL bp_release got v=%b rdy=%b want v=1 rdy=000010", rsp_valid[2], req_ready);
      end
      tick();
      half();
      vectors++;
      if (req_ready !== 6'b000100) begin
         errors++;
         $display("FAIL bp_regrant got=%b want=000100", req_ready);
      end
      tick();
      drain();
   endtask

   task automatic test_wrap();
      req_data  = 12'($urandom);
      req_valid = 6'b100000;
      half();
      vectors++;
      if (req_ready !== 6'b100000) begin
         errors++;
         $display("FAIL wrap_five got=%b want=100000", req_ready);
      end
      tick();
      req_valid = 6'b010001;
      half();
      vectors++;
      if (req_ready !== 6'b000001) begin
         errors++;
         $display("FAIL wrap_zero got=%b want=000001", req_ready);
      end
      tick();
      req_valid = 6'b010000;
      half();
      vectors++;
      if (req_ready !== 6'b010000) begin
         errors++;
         $display("FAIL wrap_four got=%b want=010000", req_ready);
      end
      tick();
      drain();
   endtask

   task automatic test_reset_midflight();
      req_data  = 12'($urandom);
      req_valid = 6'b000011;
      half();
      tick();
      half();
      tick();
      req_valid = 6'b101010;
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({req_ready, stg_valid, stg_i, rsp_valid, rsp_data, busy} !== '0) begin
         errors++;
         $display("FAIL midflight_clear got rdy=%b sv=%b si=%b rv=%b rd=%b busy=%b want all 0",
                  req_ready, stg_valid, stg_i, rsp_valid, rsp_data, busy);
      end
      for (int c = 0; c < 2; c++) begin
         half();
         tick();
      end
      rst = 1'b0;
      half();
      vectors++;
      if (req_ready !== 6'b000010) begin
         errors++;
         $display("FAIL midflight_first got=%b want=000010", req_ready);
      end
      tick();
      req_valid = '0;
      for (int c = 1; c < 4; c++) begin
         half();
         vectors++;
         if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL midflight_stale c=%0d got=%b want=000000", c, rsp_valid);
         end
         tick();
      end
      half();
      vectors++;
      if (rsp_valid !== 6'b000010) begin
         errors++;
         $display("FAIL midflight_rsp got=%b want=000010", rsp_valid);
      end
      tick();
      drain();
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_single();
      test_backpressure();
      test_wrap();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stage_share_arbiter.md
# stage_share_arbiter

- Shares one 2-input/2-output `mod4Bports`-style processing stage among NREQ independent requesters.
- Each requester presents an I1/I2 pair with a valid/ready handshake. A round-robin arbiter issues at most one pair per cycle into the stage, and a tag pipeline matches each stage result to its requester.
- The block sits in front of a single shared stage and replaces the replicated per-pair stage chains in the TestModule fabric.

## Interface
Parameters:
- NREQ, 6, number of requesters (2..16).
- LAT, 2, fixed latency of the shared stage in cycles, STG_VALID to STG_O valid (1..4).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous assert, active-high.
- REQ_VALID  in  NREQ  bit k: requester k has a pair to issue.
- REQ_DATA  in  2*NREQ  requester k uses bits [2k+1:2k]; bit 2k = I1, bit 2k+1 = I2.
- REQ_READY  out  NREQ  one-hot grant, combinational from REQ_VALID and state.
- STG_I  out  2  registered pair to the shared stage (bit0 = I1, bit1 = I2).
- STG_VALID  out  1  registered; STG_I is valid this cycle.
- STG_O  in  2  stage result, valid exactly LAT cycles after the matching STG_VALID.
- RSP_VALID  out  NREQ  bit k: response register k is full.
- RSP_DATA  out  2*NREQ  per-requester response register, same packing as REQ_DATA.
- RSP_READY  in  NREQ  bit k: requester k accepts its response.
- BUSY  out  1  OR of all outstanding flags.

## Operation
- **Handshake.**
  - A transfer occurs when REQ_VALID[k] & REQ_READY[k].
  - A requester holds REQ_VALID and its REQ_DATA slice stable until the transfer completes.
  - A response transfer occurs when RSP_VALID[k] & RSP_READY[k].
- **Outstanding flag.**
  - outstanding[k] is set on the request transfer and cleared on the response transfer.
  - Requester k is eligible only when REQ_VALID[k] & ~outstanding[k]. At most one transaction per requester is ever in flight, so no response ever needs dropping.
- **Arbitration.**
  - The pointer `last` holds the index of the most recent grant.
  - Grant goes to the first eligible index, searching from last+1 upward and wrapping from NREQ-1 to 0.
  - `last` updates only on a grant; no grant leaves it unchanged.
- **Issue.** On a transfer from k, the next cycle has STG_VALID=1, STG_I=REQ_DATA[2k+1:2k], and tag k enters a LAT+1 deep tag/valid shift pipeline.
- **Capture.**
  - When the pipeline output is valid with tag k, STG_O is written to RSP_DATA[2k+1:2k] and RSP_VALID[k] sets.
  - The register holds until accepted.
  - STG_O is ignored whenever the pipeline output is invalid.
- **Simultaneous events.** A response accept and a new request from the same k in the same cycle: the new request is not granted that cycle, because outstanding is still set. It is granted no earlier than the next cycle.
- **Reset.**
  - RST clears all registers and outputs: REQ_READY=0, STG_VALID=0, STG_I=0, RSP_VALID=0, RSP_DATA=0, BUSY=0, outstanding=0, tag pipeline empty.
  - `last` resets to NREQ-1, so requester 0 has first priority.
  - Reset mid-operation discards every in-flight transaction; stage results arriving afterwards are ignored.

## Timing
- **Latency.** Request transfer at cycle t gives STG_VALID at t+1 and STG_O at t+1+LAT. RSP_VALID[k] is high at t+2+LAT. With LAT=2, request at t yields response visible at t+4.
- **Throughput.** One issue per cycle when any requester is eligible; no bubbles between different requesters.
- **Re-request.** Requester k can be granted again at the earliest one cycle after its response transfer.
- **Combinational path.** REQ_READY depends combinationally on REQ_VALID, outstanding and `last` only, never on RSP_READY.
- **Registered outputs.** All other outputs are registered.
- **Reset release.** The first grant is possible in the first clock edge after RST deasserts.

## Test plan
The bench models the stage as an LAT-cycle delay line with STG_O = ~STG_I. All scenarios use LAT=2, NREQ=6.
- **Single request.**
  - Stimulus: REQ_VALID[3]=1 with REQ_DATA[7:6]=2'b10 at cycle 0, RSP_READY all 1.
  - Response: REQ_READY=6'b001000 at cycle 0; STG_VALID=1 with STG_I=2'b10 at cycle 1; RSP_VALID[3]=1 with RSP_DATA[7:6]=2'b01 at cycle 4; BUSY low from cycle 5.
- **Full load.**
  - Stimulus: all six REQ_VALID held high, RSP_READY all 1.
  - Response: grants 0,1,2,3,4,5 in cycles 0-5, then 0 again at cycle 6; STG_VALID continuously 1 from cycle 1.
- **Backpressure.**
  - Stimulus: RSP_READY[2]=0 for 10 cycles while all six requesters stay active.
  - Response: RSP_VALID[2] and RSP_DATA[5:4] stay stable; requester 2 is never granted; the other five keep rotating. Requester 2 is granted again one cycle after RSP_READY[2] rises.
- **Wrap fairness.**
  - Stimulus: after a grant to 5, REQ_VALID[0] and REQ_VALID[4] assert together.
  - Response: grant 0 first, then 4 in the next cycle.
- **Reset mid-flight.**
  - Stimulus: assert RST asynchronously while two transactions are in the tag pipeline.
  - Response: all outputs 0 immediately; no RSP_VALID ever follows, despite STG_O toggling; the first grant after release goes to the lowest-indexed active requester.
